// File: rtl/mfcc_out_fifo_wr_arbiter.sv
// Round-robin, frame-granular arbiter for the MFCC output FIFO write port.
// Define MFCC_ARB_ABORT_EN to add frame_abort and release the grant when req[g] drops mid-frame.

module mfcc_arb_lane #(
  parameter int DATA_W = 32
) (
  input  logic              sel,
  input  logic              full,
  input  logic [DATA_W-1:0] din,
  output logic              rdy,
  output logic [DATA_W-1:0] dout
);
  assign rdy  = sel & ~full;
  assign dout = sel ? din : '0;
endmodule

module mfcc_out_fifo_wr_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      full,
  output logic [DATA_W-1:0]         push_data,
  output logic                      wren,
  output logic                      frame_done,
  output logic [15:0]               frame_cnt
`ifdef MFCC_ARB_ABORT_EN
  ,
  output logic                      frame_abort
`endif
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                           state, state_nxt;
  logic   [IW-1:0]                  last, pick;
  logic                             pick_vld;
  logic   [7:0]                     wcnt;
  logic   [NUM_REQ-1:0][DATA_W-1:0] lane_din, lane_dout;
  logic   [NUM_REQ-1:0]             sel;
  logic                             accept, last_word;
`ifdef MFCC_ARB_ABORT_EN
  logic                             drop;
`endif

  assign lane_din = req_data;
  // Gating with rst keeps the write port quiet before the synchronous reset lands.
  assign sel = rst ? '0 : grant;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    mfcc_arb_lane #(.DATA_W(DATA_W)) u_lane (
      .sel  (sel[i]),
      .full (full),
      .din  (lane_din[i]),
      .rdy  (req_ready[i]),
      .dout (lane_dout[i])
    );
  end

  always_comb begin
    push_data = '0;
    for (int k = 0; k < NUM_REQ; k++) push_data = push_data | lane_dout[k];
  end

  assign wren      = |(req_ready & req_valid);
  assign accept    = wren;
  assign last_word = accept && (wcnt == 8'(FRAME_LEN - 1));

`ifdef MFCC_ARB_ABORT_EN
  assign drop = (state == XFER) && !(|(req & grant)) && !last_word;
`endif

  // Walk from farthest to nearest so the first set bit after last wins.
  always_comb begin
    pick     = last;
    pick_vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_REQ]) begin
        pick     = IW'((int'(last) + k) % NUM_REQ);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_vld) state_nxt = XFER;
`ifdef MFCC_ARB_ABORT_EN
      XFER: if (last_word || drop) state_nxt = IDLE;
`else
      XFER: if (last_word) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      last       <= IW'(NUM_REQ - 1);
      wcnt       <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
`ifdef MFCC_ARB_ABORT_EN
      frame_abort <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
`ifdef MFCC_ARB_ABORT_EN
      frame_abort <= 1'b0;
`endif
      if (state == IDLE) begin
        if (pick_vld) begin
          grant <= ONE << pick;
          last  <= pick;
          wcnt  <= '0;
        end
      end else begin
        if (accept) wcnt <= wcnt + 8'd1;
        if (last_word) begin
          grant      <= '0;
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 16'd1;
        end
`ifdef MFCC_ARB_ABORT_EN
        else if (drop) begin
          grant       <= '0;
          frame_abort <= 1'b1;
        end
`endif
      end
    end
  end
endmodule
